// File: rtl/ot_addr_serializer.sv
// Serial frame transmitter: shifts a 16-bit address out LSB-first,
// waits for the target-select acknowledge, then (on a write) shifts
// the write data out LSB-first before pulsing release/done.
// Ports: clk, rst (sync, active-high); start/addr/wdata/write request
// inputs; addr_ack target-select acknowledge; ready, bus_data_out,
// bus_data_out_valid, bus_mode, release_out, done, err outputs.
module ot_addr_serializer #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              write,
  input  logic              addr_ack,
  output logic              ready,
  output logic              bus_data_out,
  output logic              bus_data_out_valid,
  output logic              bus_mode,
  output logic              release_out,
  output logic              done,
  output logic              err
);

  localparam int MAXW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int BW   = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam int AB   = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam int DB   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int WW   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_DATA,
    S_FIN
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic [BW-1:0]     bit_cnt;
  logic [BW-1:0]     bit_n;
  logic [WW-1:0]     wait_cnt;
  logic [WW-1:0]     wait_n;
  logic              tout_q;
  logic              tout_n;
  logic              cap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      tout_q   <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_n;
      wait_cnt <= wait_n;
      tout_q   <= tout_n;
      if (cap) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        write_q <= write;
      end
    end
  end

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    wait_n  = wait_cnt;
    tout_n  = tout_q;
    cap     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          cap     = 1'b1;
          bit_n   = '0;
          tout_n  = 1'b0;
          state_n = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bit_cnt == BW'(ADDR_W - 1)) begin
          bit_n   = '0;
          wait_n  = '0;
          state_n = S_WAIT;
        end else begin
          bit_n = bit_cnt + BW'(1);
        end
      end
      S_WAIT: begin
        if (addr_ack) begin
          bit_n   = '0;
          state_n = write_q ? S_DATA : S_FIN;
        end else if (wait_cnt == WW'(ACK_TIMEOUT - 1)) begin
          tout_n  = 1'b1;
          state_n = S_FIN;
        end else begin
          wait_n = wait_cnt + WW'(1);
        end
      end
      S_DATA: begin
        if (bit_cnt == BW'(DATA_W - 1)) begin
          bit_n   = '0;
          state_n = S_FIN;
        end else begin
          bit_n = bit_cnt + BW'(1);
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus_data_out = 1'b0;
    if (state == S_ADDR) begin
      bus_data_out = addr_q[bit_cnt[AB-1:0]];
    end else if (state == S_DATA) begin
      bus_data_out = wdata_q[bit_cnt[DB-1:0]];
    end
  end

  assign ready              = (state == S_IDLE);
  assign bus_data_out_valid = (state == S_ADDR) || (state == S_DATA);
  assign bus_mode           = (state == S_DATA);
  assign done               = (state == S_FIN);
  assign release_out        = (state == S_FIN) && !tout_q;
  assign err                = (state == S_FIN) && tout_q;

endmodule

// File: tb/tb_ot_addr_serializer.sv
// Self-checking bench for ot_addr_serializer: builds the expected
// per-cycle output trace of each transaction and compares every cycle.
module tb_ot_addr_serializer;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          write;
  logic          addr_ack;
  logic          ready;
  logic          bus_data_out;
  logic          bus_data_out_valid;
  logic          bus_mode;
  logic          release_out;
  logic          done;
  logic          err;

  int vec  = 0;
  int errs = 0;

  logic [6:0] exq[$];
  localparam logic [6:0] IDLE_V = 7'b1000000;

  ot_addr_serializer #(
    .ADDR_W(AW), .DATA_W(DW), .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr),
    .wdata(wdata), .write(write), .addr_ack(addr_ack),
    .ready(ready), .bus_data_out(bus_data_out),
    .bus_data_out_valid(bus_data_out_valid),
    .bus_mode(bus_mode), .release_out(release_out),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] obs();
    return {ready, bus_data_out_valid, bus_mode,
            bus_data_out_valid ? bus_data_out : 1'b0,
            done, release_out, err};
  endfunction

  task automatic chk(input string tag, input int k,
                     input logic [6:0] o, input logic [6:0] e);
    vec++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b (rdy,vld,mode,bit,done,rel,err)",
             tag, k, o, e);
    end
  endtask

  // Expected trace from the cycle after accept up to the idle cycle
  // following FINISH. d = cycles after the last address bit at which
  // addr_ack rises (0 = already high throughout).
  task automatic build(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input bit wr, input int d);
    bit ok;
    int w;
    exq.delete();
    for (int i = 0; i < AW; i++)
      exq.push_back({3'b010, a[i], 3'b000});
    ok = (d <= TO);
    w  = ok ? ((d < 1) ? 1 : d) : TO;
    repeat (w) exq.push_back(7'b0000000);
    if (ok && wr)
      for (int i = 0; i < DW; i++)
        exq.push_back({3'b011, wd[i], 3'b000});
    exq.push_back({4'b0000, 1'b1, ok, !ok});
    exq.push_back(IDLE_V);
  endtask

  task automatic run(input string tag, input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, input bit wr, input int d,
                     input int rst_at, input bit noise);
    build(a, wd, wr, d);
    chk({tag, "_idle"}, 0, obs(), IDLE_V);
    start    = 1'b1;
    addr     = a;
    wdata    = wd;
    write    = wr;
    addr_ack = (d == 0);
    step();
    for (int k = 1; k <= exq.size(); k++) begin
      chk(tag, k, obs(), exq[k-1]);
      if (k == rst_at) begin
        rst   = 1'b1;
        start = 1'b0;
        step();
        rst = 1'b0;
        chk({tag, "_rst"}, k + 1, obs(), IDLE_V);
        return;
      end
      addr_ack = (d == 0) || (k >= AW + d);
      start    = (noise && k < exq.size()) ? 1'($urandom) : 1'b0;
      addr     = AW'($urandom);
      wdata    = DW'($urandom);
      write    = 1'($urandom);
      step();
    end
    start    = 1'b0;
    addr_ack = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    addr     = '0;
    wdata    = '0;
    write    = 1'b0;
    addr_ack = 1'b0;
    step();
    step();
    chk("reset", 0, obs(), IDLE_V);
    rst = 1'b0;
    step();

    run("wr4005", 16'h4005, 8'hA5, 1'b1, 2, 0, 1'b0);
    run("rd8000", 16'h8000, 8'h00, 1'b0, 2, 0, 1'b0);
    run("timeout", 16'h2000, 8'h3C, 1'b1, 100, 0, 1'b0);
    run("noise", 16'h1234, 8'h5A, 1'b1, 2, 0, 1'b1);
    run("rstmid", 16'hBEEF, 8'hC3, 1'b1, 2, 6, 1'b0);
    run("after_rst", 16'hBEEF, 8'hC3, 1'b1, 2, 0, 1'b0);
    run("stale", 16'h0F0F, 8'h81, 1'b1, 0, 0, 1'b0);
    run("edge_to", 16'h7001, 8'h11, 1'b0, TO, 0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      run("rand", AW'($urandom), DW'($urandom), 1'($urandom),
          int'($urandom_range(0, 10)), 0, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
